game_ctrl: RTL
==============

Name: game_ctrl

Overview:
- Turn sequencer for the two-player card game.
- Decodes keypad commands (start, hit, stand) and issues single-cycle deal requests to the shared random-card datapath (counter, rand_gen, demux, card_value).
- Drives the whose-turn select that steers each card to player 1 or player 2.
- Accumulates both scores, detects bust and auto-stand, and declares the winner.

Parameters:
- DECK_SIZE, 40, cards available per game; cards_left reloads to this value.
- LIMIT, 21, highest non-bust score.
- DEALER_STAND, 17, score at or above which the automatic dealer stands (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle pulse; key_code is valid.
- key_code  in  4  1=hit, 2=stand, 4=start; any other code is ignored.
- card_valid  in  1  one-cycle pulse from the datapath; card_number is valid.
- card_number  in  3  dealt card rank 0..7; points = card_number+1.
- deal_en  out  1  one-cycle deal request to the datapath.
- whose  out  1  0=player 1, 1=player 2; steers the demux.
- score1  out  6  player 1 total.
- score2  out  6  player 2 total.
- cards_left  out  8  remaining deck count.
- busy  out  1  high in DEAL and WAIT.
- game_over  out  1  high in DONE.
- winner  out  2  00=none, 01=P1, 10=P2, 11=tie.

Behaviour:
- States: IDLE, TURN, DEAL, WAIT, DONE. All outputs registered.
- Reset values: state=IDLE, deal_en=0, whose=0, score1=score2=0, cards_left=DECK_SIZE, busy=0, game_over=0, winner=00.
- Reset has priority over every other event, including mid-deal (DEAL/WAIT): the pending card is discarded and a late card_valid is ignored.
- IDLE/DONE + start key -> TURN next cycle:
  - scores cleared, whose=0, cards_left=DECK_SIZE, winner=00, game_over=0.
  - Start in any other state is ignored.
- TURN + hit:
  - cards_left>0 -> DEAL.
  - cards_left==0 -> treated as stand.
- TURN + stand:
  - whose=0 -> whose=1, remain in TURN.
  - whose=1 -> DONE.
- TURN with any other code, or no key: hold.
- DEAL: deal_en=1 for exactly one cycle; cards_left decrements the same cycle; -> WAIT.
- WAIT: waits indefinitely for card_valid, then adds card_number+1 to the current player's score (registered; visible the following cycle). Next state by new score:
  - new score > LIMIT (bust): whose=0 -> winner=10, DONE; whose=1 -> winner=01, DONE.
  - new score == LIMIT: automatic stand (same as a stand in TURN).
  - otherwise: -> TURN.
- key_valid in DEAL/WAIT is ignored, not queued. card_valid outside WAIT is ignored.
- Entering DONE without a bust: winner = 01 if score1>score2, 10 if score2>score1, 11 if equal.
- Latency: hit key to deal_en = 1 cycle; card_valid to score update = 1 cycle.
- Score width: maximum is LIMIT+8 = 29, which fits in 6 bits; no wrap.

Optional Feature:
- Macro: DEALER_AUTO_EN.
- Defined: player 2 is automatic. In TURN with whose=1 the controller ignores keys and:
  - internally issues hit while score2 < DEALER_STAND and cards_left>0;
  - otherwise issues stand.
  - Player 1 is unchanged.
- Undefined: player 2 uses keypad hit/stand exactly like player 1; DEALER_STAND is unused.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs at reset values; cards_left=40; hit/stand keys while in IDLE produce no deal_en.
- Basic deal: start, hit, card_number=4 -> deal_en pulses 1 cycle, cards_left=39, score1=5, back in TURN.
- Player 1 bust: start; P1 hits cards 7,7,7 (score 24) -> winner=10, game_over=1, no further deal_en.
- Stand/compare: P1 cards 7,5 (score 14) then stand; P2 cards 7,6 (15) then stand -> winner=10. Repeat with P2 14 -> winner=11.
- Auto-stand and deck empty: LIMIT=21 with cards totalling exactly 21 -> whose flips with no stand key. DECK_SIZE=2 after two deals -> hit acts as stand, no deal_en.
- Mid-deal reset plus DEALER_AUTO_EN: rst in WAIT -> IDLE, late card_valid ignored. With macro: P2 auto-hits until score2>=17 then DONE, and P2 keys are ignored.

Source files
------------

// File: rtl/game_ctrl.sv
// Turn sequencer for the two-player card game: decodes keypad commands, requests cards, keeps score and picks the winner.
// Optional build macro DEALER_AUTO_EN makes player 2 an automatic dealer that hits below DEALER_STAND.
module game_ctrl #(
    parameter int DECK_SIZE    = 40,
    parameter int LIMIT        = 21,
    parameter int DEALER_STAND = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       card_valid,
    input  logic [2:0] card_number,
    output logic       deal_en,
    output logic       whose,
    output logic [5:0] score1,
    output logic [5:0] score2,
    output logic [7:0] cards_left,
    output logic       busy,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        DEAL,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] KEY_HIT   = 4'd1;
    localparam logic [3:0] KEY_STAND = 4'd2;
    localparam logic [3:0] KEY_START = 4'd4;

    localparam logic [7:0] DECK_INIT   = 8'(DECK_SIZE);
    localparam logic [6:0] LIMIT_W     = 7'(LIMIT);
    localparam logic [5:0] DEALER_W    = 6'(DEALER_STAND);

`ifdef DEALER_AUTO_EN
    localparam logic P2_AUTO = 1'b1;
`else
    localparam logic P2_AUTO = 1'b0;
`endif

    state_t     state;
    logic [5:0] cur_score;
    logic [6:0] new_score;
    logic       auto_hit;
    logic       do_hit;
    logic       do_stand;

    function automatic logic [1:0] compare_scores(input logic [5:0] a, input logic [5:0] b);
        if (a > b)
            return 2'b01;
        else if (b > a)
            return 2'b10;
        else
            return 2'b11;
    endfunction

    always_comb begin
        cur_score = whose ? score2 : score1;
        new_score = {1'b0, cur_score} + {4'b0000, card_number} + 7'd1;
        auto_hit  = (score2 < DEALER_W) && (cards_left != 8'd0);
    end

    // Turn decision: an empty deck turns a hit into a stand; the automatic dealer overrides the keypad.
    always_comb begin
        do_hit   = 1'b0;
        do_stand = 1'b0;
        if (whose && P2_AUTO) begin
            if (auto_hit)
                do_hit = 1'b1;
            else
                do_stand = 1'b1;
        end else if (key_valid) begin
            if (key_code == KEY_HIT) begin
                if (cards_left != 8'd0)
                    do_hit = 1'b1;
                else
                    do_stand = 1'b1;
            end else if (key_code == KEY_STAND) begin
                do_stand = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            deal_en    <= 1'b0;
            whose      <= 1'b0;
            score1     <= 6'd0;
            score2     <= 6'd0;
            cards_left <= DECK_INIT;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
        end else begin
            deal_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (key_valid && key_code == KEY_START) begin
                        state      <= TURN;
                        score1     <= 6'd0;
                        score2     <= 6'd0;
                        whose      <= 1'b0;
                        cards_left <= DECK_INIT;
                        winner     <= 2'b00;
                        game_over  <= 1'b0;
                    end
                end
                TURN: begin
                    if (do_hit) begin
                        state      <= DEAL;
                        deal_en    <= 1'b1;
                        busy       <= 1'b1;
                        cards_left <= cards_left - 8'd1;
                    end else if (do_stand) begin
                        if (!whose) begin
                            whose <= 1'b1;
                        end else begin
                            state     <= DONE;
                            game_over <= 1'b1;
                            winner    <= compare_scores(score1, score2);
                        end
                    end
                end
                DEAL: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (card_valid) begin
                        busy <= 1'b0;
                        if (!whose)
                            score1 <= new_score[5:0];
                        else
                            score2 <= new_score[5:0];
                        // The winner compare must use the fresh total since the score register updates this same edge.
                        if (new_score > LIMIT_W) begin
                            state     <= DONE;
                            game_over <= 1'b1;
                            winner    <= whose ? 2'b01 : 2'b10;
                        end else if (new_score == LIMIT_W) begin
                            if (!whose) begin
                                whose <= 1'b1;
                                state <= TURN;
                            end else begin
                                state     <= DONE;
                                game_over <= 1'b1;
                                winner    <= compare_scores(score1, new_score[5:0]);
                            end
                        end else begin
                            state <= TURN;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
